// File: rtl/golomb_mark_counter.sv
// golomb_mark_counter: one Golomb-ruler mark; searches the next legal position when enabled==POSITION (ports: clock, RESET, enabled, prev_value, maxallowed, firstvalue, marks, distances in; m, next_value, next_enabled, pairdistsHash, ready, good out)
module golomb_mark_counter #(
  parameter int POSITION = 1,
  parameter int MAXVALUE = 22,
  parameter int NUMPOSITIONS = 5
) (
  input  logic                          clock,
  input  logic                          RESET,
  output logic                          ready,
  input  logic [8:0]                    firstvalue,
  input  logic [8:0]                    prev_value,
  input  logic [8:0]                    maxallowed,
  input  logic [6:0]                    enabled,
  output logic [8:0]                    m,
  output logic [6:0]                    next_enabled,
  output logic [8:0]                    next_value,
  input  logic [MAXVALUE:0]             distances,
  output logic [MAXVALUE:0]             pairdistsHash,
  input  logic [(NUMPOSITIONS+1)*9-1:0] marks,
  output logic                          good
);
  typedef enum logic [1:0] {IDLE, SEARCH, HOLD} state_t;
  localparam bit LEAF = POSITION == NUMPOSITIONS;
  if (POSITION == 0) begin : g_head
    logic unused_in;
    assign unused_in = ^{clock, RESET, firstvalue, prev_value, maxallowed, enabled, distances, marks};
    assign ready = 1'b1;
    assign m = '0;
    assign next_value = 9'd1;
    assign next_enabled = '0;
    assign pairdistsHash = '0;
    assign good = 1'b0;
  end else begin : g_mark
    state_t state, state_n;
    logic [8:0] mq, mq_n, cand, cand_n, limit;
    logic [6:0] ne, ne_n;
    logic gq, gq_n, coll, act, unused_marks;
    logic [8:0] mk [POSITION];
    logic [MAXVALUE:0] other;
    for (genvar k = 0; k < POSITION; k++) begin : g_mk
      assign mk[k] = marks[(NUMPOSITIONS-k)*9 +: 9];
    end
    assign unused_marks = ^marks;
    assign act = enabled == 7'(POSITION);
    assign limit = maxallowed < 9'(MAXVALUE) ? maxallowed : 9'(MAXVALUE);
    assign m = mq;
    assign next_value = mq + 9'd1;
    assign next_enabled = ne;
    assign good = gq;
    assign ready = !(state == SEARCH || (state == IDLE && act));
    always_comb begin
      pairdistsHash = '0;
      for (int j = 0; j < POSITION; j++)
        for (int i = 1; i <= MAXVALUE; i++)
          if (mq != '0 && mq - mk[j] == 9'(i)) pairdistsHash[i] = 1'b1;
    end
    // own distances are excluded so a backtracking mark does not collide with itself
    assign other = distances & ~pairdistsHash;
    always_comb begin
      coll = 1'b0;
      for (int j = 0; j < POSITION; j++)
        for (int i = 0; i <= MAXVALUE; i++)
          if (other[i] && cand - mk[j] == 9'(i)) coll = 1'b1;
    end
    always_comb begin
      state_n = state;
      mq_n = mq;
      cand_n = cand;
      ne_n = ne;
      gq_n = gq;
      case (state)
        IDLE: if (act) begin
          state_n = SEARCH;
          cand_n = mq == '0 ? prev_value : mq + 9'd1;
        end
        SEARCH: if (cand > limit) begin
          state_n = HOLD;
          mq_n = '0;
          gq_n = 1'b0;
          ne_n = 7'(POSITION - 1);
        end else if (coll) begin
          cand_n = cand + 9'd1;
        end else begin
          state_n = HOLD;
          mq_n = cand;
          gq_n = LEAF;
          ne_n = LEAF ? 7'(POSITION - 1) : 7'(POSITION + 1);
        end
        HOLD: if (!act) begin
          state_n = IDLE;
          mq_n = LEAF ? '0 : mq;
          gq_n = LEAF ? 1'b0 : gq;
        end
        default: state_n = IDLE;
      endcase
    end
    always_ff @(posedge clock) begin
      if (RESET) begin
        state <= IDLE;
        mq <= firstvalue;
        cand <= '0;
        ne <= 7'(POSITION - 1);
        gq <= 1'b0;
      end else begin
        state <= state_n;
        mq <= mq_n;
        cand <= cand_n;
        ne <= ne_n;
        gq <= gq_n;
      end
    end
  end
endmodule

// File: tb/tb_golomb_mark_counter.sv
// tb_golomb_mark_counter: randomized and directed checks of mark instances at positions 1, 2 and 5 against a search model
module tb_golomb_mark_counter;
  localparam int MV = 22;
  typedef int arr_t [6];
  logic clock = 1'b0, RESET;
  logic [8:0] firstvalue, prev_value, maxallowed;
  logic [6:0] enabled;
  logic [MV:0] distances;
  logic [53:0] marks;
  logic r1, r2, r5, g1, g2, g5, cur_ready, cur_good;
  logic [8:0] m1, m2, m5, nv1, nv2, nv5, cur_m, cur_nv;
  logic [6:0] ne1, ne2, ne5, cur_ne;
  logic [MV:0] h1, h2, h5, cur_h;
  int sel, vec = 0, err = 0;
  golomb_mark_counter #(.POSITION(1)) u1 (.clock(clock), .RESET(RESET), .ready(r1), .firstvalue(firstvalue),
    .prev_value(prev_value), .maxallowed(maxallowed), .enabled(enabled), .m(m1), .next_enabled(ne1),
    .next_value(nv1), .distances(distances), .pairdistsHash(h1), .marks(marks), .good(g1));
  golomb_mark_counter #(.POSITION(2)) u2 (.clock(clock), .RESET(RESET), .ready(r2), .firstvalue(firstvalue),
    .prev_value(prev_value), .maxallowed(maxallowed), .enabled(enabled), .m(m2), .next_enabled(ne2),
    .next_value(nv2), .distances(distances), .pairdistsHash(h2), .marks(marks), .good(g2));
  golomb_mark_counter #(.POSITION(5)) u5 (.clock(clock), .RESET(RESET), .ready(r5), .firstvalue(firstvalue),
    .prev_value(prev_value), .maxallowed(maxallowed), .enabled(enabled), .m(m5), .next_enabled(ne5),
    .next_value(nv5), .distances(distances), .pairdistsHash(h5), .marks(marks), .good(g5));
  always #5 clock = ~clock;
  always_comb begin
    cur_ready = sel == 0 ? r1 : sel == 1 ? r2 : r5;
    cur_good = sel == 0 ? g1 : sel == 1 ? g2 : g5;
    cur_m = sel == 0 ? m1 : sel == 1 ? m2 : m5;
    cur_nv = sel == 0 ? nv1 : sel == 1 ? nv2 : nv5;
    cur_ne = sel == 0 ? ne1 : sel == 1 ? ne2 : ne5;
    cur_h = sel == 0 ? h1 : sel == 1 ? h2 : h5;
  end
  function automatic logic [MV:0] dset_of(input arr_t lm, input int pos);
    dset_of = '0;
    for (int j = 0; j < pos; j++)
      for (int k = j + 1; k < pos; k++)
        if (lm[k] - lm[j] >= 1 && lm[k] - lm[j] <= MV) dset_of[lm[k] - lm[j]] = 1'b1;
  endfunction
  function automatic logic [MV:0] hash_of(input arr_t lm, input int pos, input int a);
    hash_of = '0;
    if (a != 0)
      for (int j = 0; j < pos; j++)
        if (a - lm[j] >= 1 && a - lm[j] <= MV) hash_of[a - lm[j]] = 1'b1;
  endfunction
  task automatic model(input arr_t lm, input int pos, input int start, input int mx, output int acc, output int clocks);
    logic [MV:0] ds;
    int lim, c;
    bit hit;
    ds = dset_of(lm, pos);
    lim = mx < MV ? mx : MV;
    c = start;
    clocks = 0;
    acc = 0;
    while (1) begin
      clocks++;
      if (c > lim) break;
      hit = 0;
      for (int j = 0; j < pos; j++)
        if (c - lm[j] >= 0 && c - lm[j] <= MV && ds[c - lm[j]]) hit = 1;
      if (!hit) begin
        acc = c;
        break;
      end
      c++;
    end
  endtask
  task automatic do_reset(input logic [8:0] fv);
    RESET = 1'b1;
    firstvalue = fv;
    enabled = '0;
    @(posedge clock);
    #1;
    RESET = 1'b0;
  endtask
  task automatic setup(input arr_t lm, input int pos, input int prev, input int mx, input logic [MV:0] extra);
    marks = '0;
    for (int j = 0; j < 6; j++) marks[(5-j)*9 +: 9] = 9'(lm[j]);
    prev_value = 9'(prev);
    maxallowed = 9'(mx);
    distances = dset_of(lm, pos) | extra;
  endtask
  task automatic run(input int pos, output logic r0, output int edges);
    enabled = 7'(pos);
    #1;
    r0 = cur_ready;
    edges = 0;
    do begin
      @(posedge clock);
      #1;
      edges++;
    end while (cur_ready !== 1'b1 && edges < 600);
  endtask
  task automatic test_reset;
    sel = 1;
    do_reset(9'd0);
    vec++; if (cur_m !== 9'd0) begin err++; $display("FAIL reset_m: got %0d want 0", cur_m); end
    vec++; if (cur_ready !== 1'b1) begin err++; $display("FAIL reset_ready: got %b want 1", cur_ready); end
    vec++; if (cur_nv !== 9'd1) begin err++; $display("FAIL reset_next_value: got %0d want 1", cur_nv); end
    vec++; if (cur_h !== '0) begin err++; $display("FAIL reset_hash: got %h want 0", cur_h); end
    vec++; if (cur_good !== 1'b0) begin err++; $display("FAIL reset_good: got %b want 0", cur_good); end
    vec++; if (cur_ne !== 7'd1) begin err++; $display("FAIL reset_next_enabled: got %0d want 1", cur_ne); end
  endtask
  task automatic test_first_mark;
    arr_t lm = '{0, 0, 0, 0, 0, 0};
    logic r0;
    int e, acc, clk;
    sel = 0;
    do_reset(9'd0);
    setup(lm, 1, 1, 22, '0);
    model(lm, 1, 1, 22, acc, clk);
    run(1, r0, e);
    vec++; if (r0 !== 1'b0) begin err++; $display("FAIL p1_ready_low: got %b want 0", r0); end
    vec++; if (e !== clk + 1) begin err++; $display("FAIL p1_latency: got %0d want %0d", e, clk + 1); end
    vec++; if (cur_m !== 9'(acc)) begin err++; $display("FAIL p1_m: got %0d want %0d", cur_m, acc); end
    vec++; if (cur_ne !== 7'd2) begin err++; $display("FAIL p1_next_enabled: got %0d want 2", cur_ne); end
    vec++; if (cur_h !== hash_of(lm, 1, acc)) begin err++; $display("FAIL p1_hash: got %h want %h", cur_h, hash_of(lm, 1, acc)); end
    vec++; if (cur_nv !== 9'(acc + 1)) begin err++; $display("FAIL p1_next_value: got %0d want %0d", cur_nv, acc + 1); end
  endtask
  task automatic test_middle(input int mx);
    arr_t lm = '{0, 1, 0, 0, 0, 0};
    logic r0;
    int e, acc, clk;
    sel = 1;
    do_reset(9'd0);
    setup(lm, 2, 2, mx, '0);
    model(lm, 2, 2, mx, acc, clk);
    run(2, r0, e);
    vec++; if (e !== clk + 1) begin err++; $display("FAIL p2_latency_%0d: got %0d want %0d", mx, e, clk + 1); end
    vec++; if (cur_m !== 9'(acc)) begin err++; $display("FAIL p2_m_%0d: got %0d want %0d", mx, cur_m, acc); end
    vec++; if (cur_ne !== (acc != 0 ? 7'd3 : 7'd1)) begin err++; $display("FAIL p2_next_enabled_%0d: got %0d want %0d", mx, cur_ne, acc != 0 ? 3 : 1); end
    vec++; if (cur_h !== hash_of(lm, 2, acc)) begin err++; $display("FAIL p2_hash_%0d: got %h want %h", mx, cur_h, hash_of(lm, 2, acc)); end
  endtask
  task automatic test_leaf;
    arr_t lm = '{0, 1, 4, 10, 12, 0};
    logic r0;
    int e, acc, clk;
    sel = 2;
    do_reset(9'd0);
    setup(lm, 5, 13, 17, '0);
    model(lm, 5, 13, 17, acc, clk);
    run(5, r0, e);
    vec++; if (e !== clk + 1) begin err++; $display("FAIL leaf_latency: got %0d want %0d", e, clk + 1); end
    vec++; if (cur_m !== 9'(acc)) begin err++; $display("FAIL leaf_m: got %0d want %0d", cur_m, acc); end
    vec++; if (cur_good !== 1'(acc != 0)) begin err++; $display("FAIL leaf_good: got %b want %b", cur_good, acc != 0); end
    vec++; if (cur_ne !== 7'd4) begin err++; $display("FAIL leaf_next_enabled: got %0d want 4", cur_ne); end
    enabled = 7'd4;
    @(posedge clock);
    #1;
    vec++; if (cur_m !== 9'd0) begin err++; $display("FAIL leaf_clear_m: got %0d want 0", cur_m); end
    vec++; if (cur_good !== 1'b0) begin err++; $display("FAIL leaf_clear_good: got %b want 0", cur_good); end
  endtask
  task automatic test_reset_mid_search;
    arr_t lm = '{0, 1, 4, 10, 12, 0};
    sel = 2;
    do_reset(9'd0);
    setup(lm, 5, 13, 17, '0);
    enabled = 7'd5;
    repeat (3) @(posedge clock);
    #1;
    vec++; if (cur_ready !== 1'b0) begin err++; $display("FAIL mid_searching: got %b want 0", cur_ready); end
    RESET = 1'b1;
    firstvalue = 9'd7;
    @(posedge clock);
    #1;
    RESET = 1'b0;
    vec++; if (cur_m !== 9'd7) begin err++; $display("FAIL mid_reset_m: got %0d want 7", cur_m); end
    vec++; if (cur_ready !== 1'b0) begin err++; $display("FAIL mid_idle_enabled_ready: got %b want 0", cur_ready); end
    enabled = 7'd0;
    #1;
    vec++; if (cur_ready !== 1'b1) begin err++; $display("FAIL mid_idle_ready: got %b want 1", cur_ready); end
    vec++; if (cur_ne !== 7'd4) begin err++; $display("FAIL mid_next_enabled: got %0d want 4", cur_ne); end
    firstvalue = 9'd0;
  endtask
  task automatic test_random;
    arr_t lm;
    logic r0;
    int e, acc, clk, mx, prev, pos, start;
    for (int it = 0; it < 24; it++) begin
      pos = it % 2 == 0 ? 2 : 5;
      sel = pos == 2 ? 1 : 2;
      lm = '{0, 0, 0, 0, 0, 0};
      for (int j = 1; j < pos; j++) lm[j] = lm[j-1] + int'($urandom_range(1, pos == 2 ? 10 : 4));
      prev = lm[pos-1] + 1;
      mx = int'($urandom_range(0, 30));
      do_reset(9'd0);
      setup(lm, pos, prev, mx, '0);
      model(lm, pos, prev, mx, acc, clk);
      run(pos, r0, e);
      vec++; if (r0 !== 1'b0 || e !== clk + 1) begin err++; $display("FAIL rnd_fwd_latency p%0d: got %0d/%b want %0d/0", pos, e, r0, clk + 1); end
      vec++; if (cur_m !== 9'(acc)) begin err++; $display("FAIL rnd_fwd_m p%0d: got %0d want %0d", pos, cur_m, acc); end
      vec++; if (cur_h !== hash_of(lm, pos, acc)) begin err++; $display("FAIL rnd_fwd_hash p%0d: got %h want %h", pos, cur_h, hash_of(lm, pos, acc)); end
      vec++; if (cur_ne !== 7'(acc != 0 && pos == 2 ? 3 : pos - 1)) begin err++; $display("FAIL rnd_fwd_ne p%0d: got %0d", pos, cur_ne); end
      vec++; if (cur_good !== 1'(pos == 5 && acc != 0)) begin err++; $display("FAIL rnd_fwd_good p%0d: got %b", pos, cur_good); end
      if (pos == 2) begin
        enabled = 7'd3;
        @(posedge clock);
        #1;
        setup(lm, 2, prev, mx, hash_of(lm, 2, acc));
        start = acc == 0 ? prev : acc + 1;
        model(lm, 2, start, mx, acc, clk);
        run(2, r0, e);
        vec++; if (e !== clk + 1) begin err++; $display("FAIL rnd_back_latency: got %0d want %0d", e, clk + 1); end
        vec++; if (cur_m !== 9'(acc)) begin err++; $display("FAIL rnd_back_m: got %0d want %0d", cur_m, acc); end
        vec++; if (cur_h !== hash_of(lm, 2, acc)) begin err++; $display("FAIL rnd_back_hash: got %h want %h", cur_h, hash_of(lm, 2, acc)); end
      end
    end
  endtask
  initial begin
    RESET = 1'b0;
    firstvalue = '0;
    prev_value = '0;
    maxallowed = '0;
    enabled = '0;
    distances = '0;
    marks = '0;
    sel = 0;
    test_reset;
    test_first_mark;
    test_middle(22);
    test_middle(2);
    test_leaf;
    test_reset_mid_search;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
